// File: rtl/ulpi_reg_sequencer.sv
// Scripted ULPI register access sequencer: runs up to DEPTH read/write entries
// against the ULPI register port with retry, timeout, read capture and looping.
module ulpi_reg_sequencer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DELAY_W   = 12,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                                CLK_60M,
    input  logic                                NRST_A_USB,
    input  logic                                CFG_WE,
    input  logic [$clog2(DEPTH)-1:0]            CFG_IDX,
    input  logic [ADDR_W+DATA_W+DELAY_W:0]      CFG_ENTRY,
    input  logic [$clog2(DEPTH):0]              ENTRY_CNT,
    input  logic                                START,
    input  logic                                LOOP,
    input  logic                                ABORT,
    input  logic                                READY,
    output logic                                REG_EN,
    output logic                                REG_RW,
    output logic [ADDR_W-1:0]                   REG_ADDR,
    output logic [DATA_W-1:0]                   REG_DATA_I,
    input  logic [DATA_W-1:0]                   REG_DATA_O,
    input  logic                                REG_DONE,
    input  logic                                REG_FAIL,
    output logic                                BUSY,
    output logic                                RUN_DONE,
    output logic                                RUN_ERR,
    output logic [$clog2(DEPTH)-1:0]            ERR_IDX,
    output logic                                RD_VALID,
    output logic [$clog2(DEPTH)-1:0]            RD_IDX,
    output logic [DATA_W-1:0]                   RD_DATA
);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W + DELAY_W;
    localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELAY, S_NEXT} state_t;

    logic [ENTRY_W-1:0] tbl_q [DEPTH];

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [TO_W-1:0]    tmo_q, tmo_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic               abort_q, abort_d;
    logic               reg_en_q, reg_en_d;
    logic               reg_rw_q, reg_rw_d;
    logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]  reg_data_q, reg_data_d;
    logic               busy_q, busy_d;
    logic               run_done_q, run_done_d;
    logic               run_err_q, run_err_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic               rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic               cfg_wr, fwd, issue;
    logic               cur_rw, nxt_rw;
    logic [DELAY_W-1:0] cur_dly;
    logic [ADDR_W-1:0]  nxt_addr;
    logic [DATA_W-1:0]  nxt_data;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        dly_d      = dly_q;
        abort_d    = abort_q | (ABORT && (state_q != S_IDLE));
        run_done_d = 1'b0;
        run_err_d  = run_err_q;
        err_idx_d  = err_idx_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_data_d  = rd_data_q;
        cfg_wr     = CFG_WE && (state_q == S_IDLE);
        cur_rw     = tbl_q[idx_q][ENTRY_W-1];
        cur_dly    = tbl_q[idx_q][DELAY_W-1:0];

        if (READY) begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        run_err_d = 1'b0;
                        if (ENTRY_CNT == '0) begin
                            run_done_d = 1'b1;
                        end else begin
                            cnt_d   = ENTRY_CNT;
                            idx_d   = '0;
                            retry_d = '0;
                            abort_d = 1'b0;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (REG_DONE) begin
                        if (!cur_rw) begin
                            rd_valid_d = 1'b1;
                            rd_idx_d   = idx_q;
                            rd_data_d  = REG_DATA_O;
                        end
                        dly_d   = cur_dly;
                        state_d = S_DELAY;
                    end else if (REG_FAIL || (tmo_q == TO_W'(TIMEOUT - 1))) begin
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RTY_W'(1);
                            state_d = S_ISSUE;
                        end else begin
                            run_err_d = 1'b1;
                            err_idx_d = idx_q;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        tmo_d = tmo_q + TO_W'(1);
                    end
                end
                S_DELAY: begin
                    if (dly_q == '0) state_d = S_NEXT;
                    else             dly_d   = dly_q - DELAY_W'(1);
                end
                S_NEXT: begin
                    retry_d = '0;
                    if (abort_q || ABORT) begin
                        state_d = S_IDLE;
                    end else if ({1'b0, idx_q} == cnt_q - (IDX_W+1)'(1)) begin
                        if (LOOP) begin
                            idx_d   = '0;
                            state_d = S_ISSUE;
                        end else begin
                            run_done_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A table write landing on the same edge as START is forwarded to the first issue.
        fwd      = cfg_wr && (CFG_IDX == idx_d);
        nxt_rw   = fwd ? CFG_ENTRY[ENTRY_W-1] : tbl_q[idx_d][ENTRY_W-1];
        nxt_addr = fwd ? CFG_ENTRY[ENTRY_W-2 -: ADDR_W] : tbl_q[idx_d][ENTRY_W-2 -: ADDR_W];
        nxt_data = fwd ? CFG_ENTRY[DELAY_W+DATA_W-1 -: DATA_W]
                       : tbl_q[idx_d][DELAY_W+DATA_W-1 -: DATA_W];

        issue      = (state_d == S_ISSUE) && (state_q != S_ISSUE);
        reg_en_d   = issue;
        reg_rw_d   = issue & nxt_rw;
        reg_addr_d = issue ? nxt_addr : '0;
        reg_data_d = issue ? nxt_data : '0;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK_60M) begin
        if (cfg_wr) tbl_q[CFG_IDX] <= CFG_ENTRY;
    end

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            dly_q      <= '0;
            abort_q    <= 1'b0;
            reg_en_q   <= 1'b0;
            reg_rw_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            busy_q     <= 1'b0;
            run_done_q <= 1'b0;
            run_err_q  <= 1'b0;
            err_idx_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            dly_q      <= dly_d;
            abort_q    <= abort_d;
            reg_en_q   <= reg_en_d;
            reg_rw_q   <= reg_rw_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            busy_q     <= busy_d;
            run_done_q <= run_done_d;
            run_err_q  <= run_err_d;
            err_idx_q  <= err_idx_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign REG_EN     = reg_en_q;
    assign REG_RW     = reg_rw_q;
    assign REG_ADDR   = reg_addr_q;
    assign REG_DATA_I = reg_data_q;
    assign BUSY       = busy_q;
    assign RUN_DONE   = run_done_q;
    assign RUN_ERR    = run_err_q;
    assign ERR_IDX    = err_idx_q;
    assign RD_VALID   = rd_valid_q;
    assign RD_IDX     = rd_idx_q;
    assign RD_DATA    = rd_data_q;
endmodule

// File: tb/tb_ulpi_reg_sequencer.sv
// Scoreboard bench for ulpi_reg_sequencer: a script-level model predicts issues,
// read captures and run outcome; a monitor compares as the DUT presents them.
module tb_ulpi_reg_sequencer;
    localparam int DEPTH = 8, ADDR_W = 6, DATA_W = 8, DELAY_W = 12;
    localparam int MAX_RETRY = 3, TIMEOUT = 255;
    localparam int IDX_W = 3, EW = 1 + ADDR_W + DATA_W + DELAY_W;
    localparam int K_DONE = 0, K_FAIL = 1, K_NONE = 2, K_BOTH = 3;

    typedef struct {
        int         kind;
        int         lat;
        logic [7:0] data;
    } resp_t;

    logic             CLK_60M, NRST_A_USB, CFG_WE, START, LOOP, ABORT, READY;
    logic [IDX_W-1:0] CFG_IDX;
    logic [EW-1:0]    CFG_ENTRY;
    logic [IDX_W:0]   ENTRY_CNT;
    logic             REG_EN, REG_RW, REG_DONE, REG_FAIL;
    logic [5:0]       REG_ADDR;
    logic [7:0]       REG_DATA_I, REG_DATA_O;
    logic             BUSY, RUN_DONE, RUN_ERR, RD_VALID;
    logic [IDX_W-1:0] ERR_IDX, RD_IDX;
    logic [7:0]       RD_DATA;

    ulpi_reg_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DELAY_W(DELAY_W),
                         .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
        .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
        .CFG_ENTRY(CFG_ENTRY), .ENTRY_CNT(ENTRY_CNT), .START(START), .LOOP(LOOP),
        .ABORT(ABORT), .READY(READY), .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR),
        .REG_DATA_I(REG_DATA_I), .REG_DATA_O(REG_DATA_O), .REG_DONE(REG_DONE),
        .REG_FAIL(REG_FAIL), .BUSY(BUSY), .RUN_DONE(RUN_DONE), .RUN_ERR(RUN_ERR),
        .ERR_IDX(ERR_IDX), .RD_VALID(RD_VALID), .RD_IDX(RD_IDX), .RD_DATA(RD_DATA));

    int total = 0, bad = 0, cyc = 0;
    logic [EW-1:0] tb_tbl [DEPTH];
    resp_t plan_q[$], resp_q[$];
    logic [14:0] exp_issue[$];
    logic [10:0] exp_rd[$];
    int issue_cyc_q[$];
    int got_done, done_cyc, last_done_cyc, start_cyc;
    bit exp_done, exp_err;
    int exp_err_idx;

    initial CLK_60M = 1'b0;
    always #5 CLK_60M = ~CLK_60M;
    initial forever begin @(posedge CLK_60M); cyc = cyc + 1; end

    initial begin
        #5ms;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: compare every presented issue / read capture against the queues.
    initial forever begin
        @(negedge CLK_60M);
        if (NRST_A_USB) begin
            if (REG_EN) begin
                issue_cyc_q.push_back(cyc);
                if (exp_issue.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_issue got=%0h exp=none", {REG_RW, REG_ADDR, REG_DATA_I});
                end else check("issue", {REG_RW, REG_ADDR, REG_DATA_I}, exp_issue.pop_front());
            end
            if (RD_VALID) begin
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read got=%0h exp=none", {RD_IDX, RD_DATA});
                end else check("read", {RD_IDX, RD_DATA}, exp_rd.pop_front());
            end
            if (RUN_DONE) begin got_done++; done_cyc = cyc; end
        end
    end

    // Responder: answers each REG_EN per the next queued response.
    initial begin
        resp_t cur;
        bit pend;
        int cd;
        REG_DONE = 0; REG_FAIL = 0; REG_DATA_O = 0; pend = 0; cd = 0;
        cur = '{K_NONE, 0, 8'h00};
        forever begin
            @(negedge CLK_60M);
            REG_DONE = 0; REG_FAIL = 0; REG_DATA_O = 8'($urandom);
            if (!NRST_A_USB) pend = 0;
            else if (REG_EN) begin
                pend = 0;
                if (resp_q.size() > 0) begin
                    cur = resp_q.pop_front();
                    pend = (cur.kind != K_NONE);
                    cd = cur.lat;
                end
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend = 0;
                    REG_DONE = (cur.kind == K_DONE) || (cur.kind == K_BOTH);
                    REG_FAIL = (cur.kind == K_FAIL) || (cur.kind == K_BOTH);
                    REG_DATA_O = cur.data;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK_60M);
    endtask

    task automatic load(input int idx, input logic rw, input logic [5:0] a,
                        input logic [7:0] d, input logic [11:0] dl);
        @(negedge CLK_60M);
        CFG_WE = 1; CFG_IDX = IDX_W'(idx); CFG_ENTRY = {rw, a, d, dl};
        tb_tbl[idx] = {rw, a, d, dl};
        @(negedge CLK_60M);
        CFG_WE = 0;
    endtask

    function automatic resp_t mk(input int kind, input int lat, input logic [7:0] data);
        resp_t r;
        r.kind = kind; r.lat = lat; r.data = data;
        return r;
    endfunction

    // Script-level model: walk entries, consume planned responses, apply retry rules.
    function automatic void predict(input int cnt, input bit loop, input int n_ent);
        resp_t r;
        int idx, attempts;
        bit ok;
        exp_err = 0; exp_done = 0; exp_err_idx = 0;
        for (int e = 0; e < n_ent; e++) begin
            idx = e % cnt; attempts = 0; ok = 0;
            while (!ok) begin
                if (plan_q.size() > 0) r = plan_q.pop_front();
                else r = mk(K_NONE, 0, 8'h00);
                resp_q.push_back(r);
                exp_issue.push_back(tb_tbl[idx][EW-1:DELAY_W]);
                if (r.kind == K_DONE || r.kind == K_BOTH) begin
                    ok = 1;
                    if (!tb_tbl[idx][EW-1]) exp_rd.push_back({3'(idx), r.data});
                end else begin
                    attempts++;
                    if (attempts > MAX_RETRY) begin
                        exp_err = 1; exp_err_idx = idx;
                        plan_q.delete();
                        return;
                    end
                end
            end
        end
        exp_done = !loop;
        plan_q.delete();
    endfunction

    task automatic begin_run(input int cnt, input bit loop, input bit with_cfg,
                             input int cidx, input logic [EW-1:0] centry);
        issue_cyc_q.delete(); got_done = 0; done_cyc = -1;
        @(negedge CLK_60M);
        ENTRY_CNT = (IDX_W+1)'(cnt); LOOP = loop; START = 1; start_cyc = cyc;
        if (with_cfg) begin CFG_WE = 1; CFG_IDX = IDX_W'(cidx); CFG_ENTRY = centry; end
        @(negedge CLK_60M);
        START = 0; CFG_WE = 0;
        ENTRY_CNT = (IDX_W+1)'($urandom_range(0, DEPTH));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((BUSY || n < 2) && n < limit) begin @(negedge CLK_60M); n++; end
        if (n >= limit) begin total++; bad++; $display("FAIL run_timeout got=busy exp=idle"); end
        tick(3);
    endtask

    task automatic end_checks();
        check("issues_left", exp_issue.size(), 0);
        check("reads_left", exp_rd.size(), 0);
        check("run_done_count", got_done, exp_done);
        check("run_err", RUN_ERR, exp_err);
        check("busy_end", BUSY, 0);
        if (exp_err) check("err_idx", ERR_IDX, exp_err_idx);
        exp_issue.delete(); exp_rd.delete(); resp_q.delete();
    endtask

    task automatic wait_issues(input int n, input int limit);
        int k = 0;
        while (issue_cyc_q.size() < n && k < limit) begin @(negedge CLK_60M); k++; end
        if (k >= limit) begin total++; bad++; $display("FAIL issue_wait got=%0d exp=%0d", issue_cyc_q.size(), n); end
    endtask

    initial begin
        logic [EW-1:0] ce;
        int cnt, ci, wc, k;
        NRST_A_USB = 0; CFG_WE = 0; CFG_IDX = 0; CFG_ENTRY = 0; ENTRY_CNT = 0;
        START = 0; LOOP = 0; ABORT = 0; READY = 1;
        tick(3);
        check("rst_reg_en", REG_EN, 0);
        check("rst_reg_fields", {REG_RW, REG_ADDR, REG_DATA_I}, 0);
        check("rst_busy", BUSY, 0);
        check("rst_run_flags", {RUN_DONE, RUN_ERR, ERR_IDX}, 0);
        check("rst_rd", {RD_VALID, RD_IDX, RD_DATA}, 0);
        NRST_A_USB = 1;
        tick(2);

        // Read then write with 10-cycle delay on the write.
        load(0, 0, 6'h04, 8'h00, 12'd0);
        load(1, 1, 6'h04, 8'h46, 12'd10);
        plan_q.push_back(mk(K_DONE, 3, 8'h41));
        plan_q.push_back(mk(K_DONE, 2, 8'h00));
        predict(2, 0, 2);
        begin_run(2, 0, 0, 0, '0);
        wait_idle(500);
        end_checks();
        check("delay_gap", done_cyc - last_done_cyc, 3 + 10);

        // Start-to-done latency for a single entry, delay 0, N=5.
        load(0, 0, 6'h11, 8'h00, 12'd0);
        plan_q.push_back(mk(K_DONE, 5, 8'h9c));
        predict(1, 0, 1);
        begin_run(1, 0, 0, 0, '0);
        wait_idle(500);
        end_checks();
        check("start_latency", done_cyc - start_cyc, 5 + 4);

        // Two failures then success.
        plan_q.push_back(mk(K_FAIL, 2, 8'h00));
        plan_q.push_back(mk(K_FAIL, 1, 8'h00));
        plan_q.push_back(mk(K_DONE, 3, 8'h5a));
        predict(1, 0, 1);
        begin_run(1, 0, 0, 0, '0);
        wait_idle(500);
        check("retry_issues", issue_cyc_q.size(), 3);
        end_checks();

        // Retries exhausted.
        repeat (4) plan_q.push_back(mk(K_FAIL, 1, 8'h00));
        predict(1, 0, 1);
        begin_run(1, 0, 0, 0, '0);
        wait_idle(500);
        check("fail_issues", issue_cyc_q.size(), 4);
        end_checks();

        // Never answered: timeout re-issue period.
        repeat (4) plan_q.push_back(mk(K_NONE, 0, 8'h00));
        predict(1, 0, 1);
        begin_run(1, 0, 0, 0, '0);
        wait_idle(2000);
        check("timeout_issues", issue_cyc_q.size(), 4);
        for (int i = 1; i < issue_cyc_q.size(); i++)
            check("timeout_period", issue_cyc_q[i] - issue_cyc_q[i-1], TIMEOUT + 1);
        end_checks();

        // READY low for 50 cycles mid-WAIT freezes the timeout.
        load(0, 1, 6'h0a, 8'h3c, 12'd0);
        plan_q.push_back(mk(K_NONE, 0, 8'h00));
        plan_q.push_back(mk(K_DONE, 2, 8'h00));
        predict(1, 0, 1);
        begin_run(1, 0, 0, 0, '0);
        wait_issues(1, 10);
        tick(20); READY = 0; tick(50); READY = 1;
        wait_idle(1000);
        check("ready_issues", issue_cyc_q.size(), 2);
        if (issue_cyc_q.size() >= 2)
            check("ready_freeze_period", issue_cyc_q[1] - issue_cyc_q[0], TIMEOUT + 1 + 50);
        end_checks();

        // ENTRY_CNT=0: immediate RUN_DONE, never busy.
        exp_done = 1; exp_err = 0;
        begin_run(0, 0, 0, 0, '0);
        check("cnt0_run_done", RUN_DONE, 1);
        check("cnt0_busy", BUSY, 0);
        tick(3);
        check("cnt0_done_cyc", done_cyc - start_cyc, 1);
        end_checks();

        // LOOP with ABORT during entry1, and a blocked table write while busy.
        load(0, 0, 6'h01, 8'h00, 12'd1);
        load(1, 0, 6'h02, 8'h00, 12'd2);
        load(2, 1, 6'h03, 8'h77, 12'd0);
        repeat (3) plan_q.push_back(mk(K_DONE, 2, 8'($urandom)));
        predict(3, 1, 2);
        begin_run(3, 1, 0, 0, '0);
        wait_issues(2, 50);
        ABORT = 1; CFG_WE = 1; CFG_IDX = 3'd2; CFG_ENTRY = {1'b0, 6'h3f, 8'hee, 12'd7};
        tick();
        ABORT = 0; CFG_WE = 0;
        wait_idle(500);
        LOOP = 0;
        check("abort_issues", issue_cyc_q.size(), 2);
        end_checks();
        repeat (3) plan_q.push_back(mk(K_DONE, 1, 8'($urandom)));
        predict(3, 0, 3);
        begin_run(3, 0, 0, 0, '0);
        wait_idle(500);
        end_checks();

        // Randomized scripts and responses.
        for (int run = 0; run < 15; run++) begin
            cnt = $urandom_range(1, DEPTH);
            for (int i = 0; i < cnt; i++)
                load(i, 1'($urandom), 6'($urandom), 8'($urandom), 12'($urandom_range(0, 4)));
            for (int i = 0; i < 40; i++) begin
                k = $urandom_range(0, 9);
                plan_q.push_back(mk((k < 6) ? K_DONE : (k < 9) ? K_FAIL : K_BOTH,
                                    $urandom_range(1, 4), 8'($urandom)));
            end
            wc = $urandom_range(0, 1);
            ci = $urandom_range(0, cnt - 1);
            ce = {1'($urandom), 6'($urandom), 8'($urandom), 12'($urandom_range(0, 4))};
            if (wc != 0) tb_tbl[ci] = ce;
            predict(cnt, 0, cnt);
            begin_run(cnt, 0, wc != 0, ci, ce);
            wait_idle(3000);
            end_checks();
        end

        // Reset mid-access drops REG_EN asynchronously, no completion pulse.
        load(0, 1, 6'h15, 8'h99, 12'd0);
        plan_q.push_back(mk(K_NONE, 0, 8'h00));
        predict(1, 0, 1);
        begin_run(1, 0, 0, 0, '0);
        k = 0;
        while (!REG_EN && k < 10) begin @(negedge CLK_60M); k++; end
        check("rst_mid_saw_issue", REG_EN, 1);
        #2 NRST_A_USB = 0;
        #1;
        check("rst_mid_reg_en", REG_EN, 0);
        check("rst_mid_busy", BUSY, 0);
        exp_issue.delete(); exp_rd.delete(); resp_q.delete();
        tick(2);
        NRST_A_USB = 1;
        tick(10);
        check("rst_mid_no_done", got_done, 0);
        check("rst_mid_idle", BUSY, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
